// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: register bank sitting on the user port of an I2C slave.
// The master writes a pointer byte followed by data bytes, or reads bytes
// from the current pointer onwards; both directions auto-increment.
// A separate single-cycle local port lets SoC logic access the same registers.
module i2c_slave_regfile #(
    parameter int          DEPTH          = 16,
    parameter int          ADDR_W         = 4,
    parameter logic [9:0]  OWN_ADDR       = 10'h050,
    parameter int          STRETCH_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic              data_vld,
    input  logic              r_w,
    input  logic [7:0]        data_write,
    output logic [7:0]        data_read,
    output logic              stretch_on,
    output logic [9:0]        Slave_Address,
    input  logic              loc_wr_en,
    input  logic              loc_rd_en,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    output logic [7:0]        loc_rdata,
    output logic              loc_rdata_vld,
    output logic              loc_wr_err,
    output logic              i2c_wr_done
);

    typedef enum logic [1:0] {IDLE, PTR, WRITE, READ} state_t;

    state_t            state, state_nxt;
    logic [7:0]        regs [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_inc;
    logic              wrote;
    logic [3:0]        stretch_cnt;
    logic              i2c_wr;
    logic              collide;
    logic              loc_wr_ok;
    logic [7:0]        cur_val;
    logic [7:0]        nxt_val;

    assign ptr_inc   = ptr + 1'b1;
    assign i2c_wr    = (state == WRITE) && data_vld && !start && !stop;
    assign collide   = i2c_wr && loc_wr_en && (loc_addr == ptr);
    assign loc_wr_ok = loc_wr_en && !collide;

    // Byte values as they will be after this edge, so a same-cycle local
    // write is not lost when data_read is loaded from the register file.
    assign cur_val = (loc_wr_ok && loc_addr == ptr)     ? loc_wdata : regs[ptr];
    assign nxt_val = (loc_wr_ok && loc_addr == ptr_inc) ? loc_wdata : regs[ptr_inc];

    // State register; reset aborts any transaction immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: start beats stop and data_vld, stop beats data_vld.
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = r_w ? READ : PTR;
        else if (stop)
            state_nxt = IDLE;
        else if (state == PTR && data_vld)
            state_nxt = WRITE;
    end

    // Outputs decoded from state: clock stretching only while reading.
    always_comb begin
        stretch_on    = (state == READ) && (stretch_cnt != 4'd0);
        Slave_Address = OWN_ADDR;
    end

    // Register file; the I2C side wins a same-index collision.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            if (i2c_wr)    regs[ptr]      <= data_write;
            if (loc_wr_ok) regs[loc_addr] <= loc_wdata;
        end
    end

    // Pointer, wrote-data flag, write-done pulse and stretch counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr         <= '0;
            wrote       <= 1'b0;
            i2c_wr_done <= 1'b0;
            stretch_cnt <= 4'd0;
        end else begin
            i2c_wr_done <= 1'b0;
            if (start) begin
                if (!r_w) wrote <= 1'b0;
                stretch_cnt <= 4'd0;
            end else if (stop) begin
                i2c_wr_done <= wrote;
                wrote       <= 1'b0;
                stretch_cnt <= 4'd0;
            end else begin
                if (stretch_cnt != 4'd0) stretch_cnt <= stretch_cnt - 4'd1;
                case (state)
                    PTR:     if (data_vld) ptr <= data_write[ADDR_W-1:0];
                    WRITE:   if (data_vld) begin
                                 ptr   <= ptr_inc;
                                 wrote <= 1'b1;
                             end
                    READ:    if (data_vld) begin
                                 ptr         <= ptr_inc;
                                 stretch_cnt <= 4'(STRETCH_CYCLES);
                             end
                    default: ;
                endcase
            end
        end
    end

    // Transmit byte: loaded on read start and after each byte is consumed;
    // a local write refreshes it only while the byte is still being prepared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_read <= 8'h00;
        end else if (start) begin
            if (r_w) data_read <= cur_val;
        end else if (!stop && state == READ) begin
            if (data_vld)
                data_read <= nxt_val;
            else if (stretch_cnt != 4'd0 && loc_wr_ok && loc_addr == ptr)
                data_read <= loc_wdata;
        end
    end

    // Local read data (read-before-write) and collision error pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            loc_rdata     <= 8'h00;
            loc_rdata_vld <= 1'b0;
            loc_wr_err    <= 1'b0;
        end else begin
            loc_rdata_vld <= loc_rd_en;
            loc_wr_err    <= collide;
            if (loc_rd_en) loc_rdata <= regs[loc_addr];
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: directed I2C user-port and local-port
// traffic, checked every cycle against a transaction-level model plus
// hand-computed literal expectations.
module tb_i2c_slave_regfile;

    localparam int STRETCH = 2;

    logic       CLK, RST;
    logic       start, stop, data_vld, r_w;
    logic [7:0] data_write, data_read;
    logic       stretch_on;
    logic [9:0] Slave_Address;
    logic       loc_wr_en, loc_rd_en;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata, loc_rdata;
    logic       loc_rdata_vld, loc_wr_err, i2c_wr_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Model: register contents, pointer, transaction mode, stretch cycles left
    logic [7:0] m_mem [16];
    int         m_ptr;
    int         m_mode;
    bit         m_wrote;
    int         m_left;
    logic [7:0] e_dr, e_rdata;
    bit         e_stretch, e_rvld, e_err, e_done;

    i2c_slave_regfile #(
        .DEPTH(16), .ADDR_W(4), .OWN_ADDR(10'h050), .STRETCH_CYCLES(STRETCH)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .data_vld(data_vld),
        .r_w(r_w), .data_write(data_write), .data_read(data_read),
        .stretch_on(stretch_on), .Slave_Address(Slave_Address),
        .loc_wr_en(loc_wr_en), .loc_rd_en(loc_rd_en), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_rdata(loc_rdata), .loc_rdata_vld(loc_rdata_vld),
        .loc_wr_err(loc_wr_err), .i2c_wr_done(i2c_wr_done)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr = 0; m_mode = 0; m_wrote = 0; m_left = 0;
        e_dr = 8'h00; e_rdata = 8'h00;
        e_stretch = 0; e_rvld = 0; e_err = 0; e_done = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    // Modes: 0 idle, 1 expecting pointer, 2 writing data, 3 reading.
    task automatic model_step();
        bit stretching, i2c_w, lw_ok;
        int tgt;
        stretching = (m_mode == 3) && (m_left > 0);
        i2c_w  = (m_mode == 2) && data_vld && !start && !stop;
        tgt    = m_ptr;
        e_err  = loc_wr_en && i2c_w && (int'(loc_addr) == tgt);
        lw_ok  = loc_wr_en && !e_err;
        e_rvld = loc_rd_en;
        if (loc_rd_en) e_rdata = m_mem[loc_addr];
        e_done = stop && !start && m_wrote;
        if (i2c_w) m_mem[tgt] = data_write;
        if (lw_ok) m_mem[loc_addr] = loc_wdata;
        if (start) begin
            if (!r_w) m_wrote = 0;
            m_left = 0;
            m_mode = r_w ? 3 : 1;
            if (r_w) e_dr = m_mem[m_ptr];
        end else if (stop) begin
            m_wrote = 0;
            m_left  = 0;
            m_mode  = 0;
        end else begin
            if (m_left > 0) m_left--;
            if (m_mode == 1 && data_vld) begin
                m_ptr  = data_write % 16;
                m_mode = 2;
            end else if (m_mode == 2 && data_vld) begin
                m_ptr   = (m_ptr + 1) % 16;
                m_wrote = 1;
            end else if (m_mode == 3 && data_vld) begin
                m_ptr  = (m_ptr + 1) % 16;
                m_left = STRETCH;
                e_dr   = m_mem[m_ptr];
            end else if (stretching && lw_ok && int'(loc_addr) == m_ptr) begin
                e_dr = loc_wdata;
            end
        end
        e_stretch = (m_mode == 3) && (m_left > 0);
    endtask

    // Drive one cycle of inputs from a negedge, update the model at the
    // posedge, and return at the following negedge.
    task automatic applyStimulus(input bit st, input bit sp, input bit dv, input bit rw,
                                 input logic [7:0] dw, input bit lwe, input bit lre,
                                 input logic [3:0] la, input logic [7:0] lwd);
        start = st; stop = sp; data_vld = dv; r_w = rw; data_write = dw;
        loc_wr_en = lwe; loc_rd_en = lre; loc_addr = la; loc_wdata = lwd;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        start = 0; stop = 0; data_vld = 0; loc_wr_en = 0; loc_rd_en = 0;
    endtask

    task automatic i2c(input bit st, input bit sp, input bit dv, input bit rw, input logic [7:0] dw);
        applyStimulus(st, sp, dv, rw, dw, 0, 0, 4'h0, 8'h00);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    endtask

    task automatic locWr(input logic [3:0] a, input logic [7:0] d);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, a, d);
    endtask

    task automatic locRd(input logic [3:0] a);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, a, 8'h00);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            checkOutput("data_read",     {2'b0, data_read},  {2'b0, e_dr});
            checkOutput("stretch_on",    {9'b0, stretch_on}, {9'b0, e_stretch});
            checkOutput("loc_rdata",     {2'b0, loc_rdata},  {2'b0, e_rdata});
            checkOutput("loc_rdata_vld", {9'b0, loc_rdata_vld}, {9'b0, e_rvld});
            checkOutput("loc_wr_err",    {9'b0, loc_wr_err}, {9'b0, e_err});
            checkOutput("i2c_wr_done",   {9'b0, i2c_wr_done}, {9'b0, e_done});
            checkOutput("Slave_Address", Slave_Address, 10'h050);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the end of the test sequence");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RST = 1; start = 0; stop = 0; data_vld = 0; r_w = 0; data_write = 0;
        loc_wr_en = 0; loc_rd_en = 0; loc_addr = 0; loc_wdata = 0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset data_read", {2'b0, data_read}, 10'h000);
        checkOutput("reset stretch_on", {9'b0, stretch_on}, 10'h000);
        checkOutput("reset Slave_Address", Slave_Address, 10'h050);
        RST = 0;
        chk_en = 1;

        // Test 1: pointer 3 then two data bytes, stop
        i2c(1, 0, 0, 0, 8'h00);
        i2c(0, 0, 1, 0, 8'h03);
        i2c(0, 0, 1, 0, 8'hAA);
        i2c(0, 0, 1, 0, 8'hBB);
        i2c(0, 1, 0, 0, 8'h00);
        checkOutput("t1 wr_done pulse", {9'b0, i2c_wr_done}, 10'h001);
        idle();
        checkOutput("t1 wr_done single", {9'b0, i2c_wr_done}, 10'h000);
        locRd(4'd3);
        checkOutput("t1 reg3", {2'b0, loc_rdata}, 10'h0AA);
        checkOutput("t1 rdata_vld", {9'b0, loc_rdata_vld}, 10'h001);
        locRd(4'd4);
        checkOutput("t1 reg4", {2'b0, loc_rdata}, 10'h0BB);

        // Test 2: read from ptr=5 with stretching after each byte
        locWr(4'd6, 8'h66);
        locWr(4'd7, 8'h77);
        i2c(1, 0, 0, 1, 8'h00);
        checkOutput("t2 first byte reg5", {2'b0, data_read}, 10'h000);
        i2c(0, 0, 1, 0, 8'h00);
        checkOutput("t2 byte reg6", {2'b0, data_read}, 10'h066);
        checkOutput("t2 stretch c1", {9'b0, stretch_on}, 10'h001);
        idle();
        checkOutput("t2 stretch c2", {9'b0, stretch_on}, 10'h001);
        idle();
        checkOutput("t2 stretch end", {9'b0, stretch_on}, 10'h000);
        i2c(0, 0, 1, 0, 8'h00);
        checkOutput("t2 byte reg7", {2'b0, data_read}, 10'h077);
        idle(); idle();
        i2c(0, 0, 1, 0, 8'h00);
        checkOutput("t2 byte reg8", {2'b0, data_read}, 10'h000);
        idle(); idle();
        i2c(0, 1, 0, 0, 8'h00);
        checkOutput("t2 no wr_done on read", {9'b0, i2c_wr_done}, 10'h000);

        // Test 3: pointer with upper bits set, writes wrap 15 -> 0 -> 1
        i2c(1, 0, 0, 0, 8'h00);
        i2c(0, 0, 1, 0, 8'h1F);
        i2c(0, 0, 1, 0, 8'hC1);
        i2c(0, 0, 1, 0, 8'hC2);
        i2c(0, 0, 1, 0, 8'hC3);
        i2c(0, 1, 0, 0, 8'h00);
        locRd(4'd15);
        checkOutput("t3 reg15", {2'b0, loc_rdata}, 10'h0C1);
        locRd(4'd0);
        checkOutput("t3 reg0", {2'b0, loc_rdata}, 10'h0C2);
        locRd(4'd1);
        checkOutput("t3 reg1", {2'b0, loc_rdata}, 10'h0C3);

        // Test 4: pointer-only write, then repeated start into a read
        locWr(4'd9, 8'h99);
        i2c(1, 0, 0, 0, 8'h00);
        i2c(0, 0, 1, 0, 8'h09);
        i2c(0, 1, 0, 0, 8'h00);
        checkOutput("t4 no wr_done", {9'b0, i2c_wr_done}, 10'h000);
        i2c(1, 0, 0, 0, 8'h00);
        i2c(0, 0, 1, 0, 8'h09);
        i2c(1, 0, 0, 1, 8'h00);
        checkOutput("t4 repeated start read", {2'b0, data_read}, 10'h099);
        i2c(0, 1, 0, 0, 8'h00);

        // Test 5: same-cycle I2C and local write to reg2
        i2c(1, 0, 0, 0, 8'h00);
        i2c(0, 0, 1, 0, 8'h02);
        applyStimulus(0, 0, 1, 0, 8'h11, 1, 0, 4'd2, 8'h22);
        checkOutput("t5 wr_err", {9'b0, loc_wr_err}, 10'h001);
        i2c(0, 1, 0, 0, 8'h00);
        checkOutput("t5 wr_done", {9'b0, i2c_wr_done}, 10'h001);
        locRd(4'd2);
        checkOutput("t5 reg2 i2c wins", {2'b0, loc_rdata}, 10'h011);

        // Local write to the shown byte: refreshes only while stretching
        i2c(1, 0, 0, 1, 8'h00);
        checkOutput("t5 read reg3", {2'b0, data_read}, 10'h0AA);
        i2c(0, 0, 1, 0, 8'h00);
        locWr(4'd4, 8'h44);
        checkOutput("t5 refresh in stretch", {2'b0, data_read}, 10'h044);
        idle(); idle();
        locWr(4'd4, 8'h45);
        checkOutput("t5 no refresh after stretch", {2'b0, data_read}, 10'h044);

        // Test 6: asynchronous reset in the middle of a stretched read
        i2c(0, 0, 1, 0, 8'h00);
        checkOutput("t6 stretch before reset", {9'b0, stretch_on}, 10'h001);
        chk_en = 0;
        #1 RST = 1;
        #1;
        checkOutput("t6 async stretch_on", {9'b0, stretch_on}, 10'h000);
        checkOutput("t6 async data_read", {2'b0, data_read}, 10'h000);
        checkOutput("t6 async loc_rdata", {2'b0, loc_rdata}, 10'h000);
        model_reset();
        @(negedge CLK);
        RST = 0;
        chk_en = 1;
        locRd(4'd3);
        checkOutput("t6 reg3 cleared", {2'b0, loc_rdata}, 10'h000);
        i2c(1, 0, 0, 1, 8'h00);
        checkOutput("t6 reg0 after reset", {2'b0, data_read}, 10'h000);
        i2c(0, 1, 0, 0, 8'h00);
        idle();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
